// File: rtl/data_sram_wbuf.sv
// data_sram_wbuf: posted-write FIFO from CPU store port to AXI write channel (WBUF_HAZARD_EN: per-address RAW compare).
// Latency: store acked one cycle after accept; pushed entry reaches data_sram_req the next cycle (no bypass).
// Backpressure: cpu_addr_ok low while DEPTH entries are held; one write transaction outstanding at a time.
module data_sram_wbuf #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [3:0]  cpu_wstrb,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] rd_addr,
  output logic        raw_hazard,
  output logic        wbuf_empty
);

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } entry_t;

  typedef enum logic {IDLE = 1'b0, WAIT_B = 1'b1} state_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  state_t           state;
  state_t           state_nxt;
  logic             push;
  logic             pop;
  logic             has_entry;

  // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot early.
  assign has_entry   = (count != '0);
  assign push        = cpu_req && cpu_wr && (count != FULL_CNT);
  assign pop         = (state == WAIT_B) && data_sram_data_ok;
  assign cpu_addr_ok = push;
  assign wbuf_empty  = !has_entry;
  assign data_sram_wr = 1'b1;

  // Head stays in place until its B response, so the payload is stable while outstanding;
  // it reads zero when empty so stale slots never appear on the bus.
  assign data_sram_addr  = has_entry ? mem[head].addr  : '0;
  assign data_sram_size  = has_entry ? mem[head].size  : '0;
  assign data_sram_wstrb = has_entry ? mem[head].wstrb : '0;
  assign data_sram_wdata = has_entry ? mem[head].wdata : '0;

  // Entry storage written at tail on accept; contents are qualified by count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= '{addr: cpu_addr, size: cpu_size, wstrb: cpu_wstrb, wdata: cpu_wdata};
    end
  end

  // Pointers, occupancy and the posted-store acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      cpu_data_ok <= 1'b0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      cpu_data_ok <= push;
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Drain FSM next state: one transaction in flight, released by its B response.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (has_entry && data_sram_addr_ok) state_nxt = WAIT_B;
      WAIT_B:  if (data_sram_data_ok)              state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Drain FSM outputs: request only while idle with a queued entry.
  always_comb begin
    data_sram_req = 1'b0;
    if (state == IDLE) data_sram_req = has_entry;
  end

`ifdef WBUF_HAZARD_EN
  logic [PTR_W-1:0] offs;
  logic             hit;

  // Word-address match against every occupied slot, in-flight head included.
  always_comb begin
    hit  = 1'b0;
    offs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PTR_W'(i) - head;
      if (({1'b0, offs} < count) && (mem[i].addr[31:2] == rd_addr[31:2])) hit = 1'b1;
    end
  end

  assign raw_hazard = hit;
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  // Conservative: any load waits until the buffer has fully drained.
  assign raw_hazard = !wbuf_empty;
`endif

endmodule
